counter_wrap_tracker: RTL and testbench
=======================================

Name: counter_wrap_tracker

Overview:
- Downstream consumer of the 4-bit free-running counter; monitors its value/full outputs and drives its clear input.
- Counts counter wrap-arounds, compares against a programmed threshold, and raises a handshaked event when the threshold is reached.
- Commands arrive over a valid/ready port; events leave over a valid/ready port to the interrupt/status logic.

Parameters:
- CNT_WIDTH, 4, width of monitored counter value.
- WRAP_WIDTH, 8, width of wrap count and threshold.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- cnt_value  input  CNT_WIDTH  counter current value (monitor only)
- cnt_full  input  1  counter at all-ones this cycle
- cnt_clear  output  1  registered one-cycle clear pulse to counter
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when valid&&ready
- cmd_op  input  2  0 NOP, 1 ARM, 2 DISARM, 3 CLEAR
- cmd_threshold  input  WRAP_WIDTH  threshold loaded by ARM
- evt_valid  output  1  event pending
- evt_ready  input  1  event consumed when valid&&ready
- evt_wraps  output  WRAP_WIDTH  wrap count captured at event
- wraps  output  WRAP_WIDTH  live saturating wrap count

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, wraps=0, threshold=0, evt_wraps=0, evt_valid=0, cnt_clear=0; cmd_ready=1 next cycle.
- wrap_evt = cnt_full && !cnt_clear (counter increments every cycle; a clear in flight suppresses the wrap).
- wraps: +1 per wrap_evt, saturates at 2^WRAP_WIDTH-1, never rolls over; updated on edge after wrap (1-cycle latency).
- States IDLE, ARMED, PENDING; cmd_ready = (state != PENDING).
- IDLE: wraps counts; ARM -> ARMED; DISARM no-op; CLEAR zeroes wraps, pulses cnt_clear.
- ARM (IDLE/ARMED): threshold<=cmd_threshold, wraps<=0 (concurrent wrap_evt discarded), cnt_clear<=1 for one cycle. cmd_threshold==0: treated as CLEAR, state -> IDLE.
- ARMED: when wrap_evt and wraps+1 == threshold -> PENDING, evt_valid<=1, evt_wraps<=threshold (same edge as wraps update). DISARM -> IDLE, wraps held, concurrent wrap counted. CLEAR as in IDLE, stays ARMED.
- PENDING: evt_valid and evt_wraps held stable until accepted; wraps keeps counting (saturating). On evt_valid&&evt_ready -> ARMED, evt_valid<=0, wraps<=0, or 1 if wrap_evt same cycle.
- Command and wrap in same cycle: ARM/CLEAR win (wraps=0); DISARM/NOP let wrap count. ARMED threshold hit plus CLEAR same cycle: CLEAR wins, no event.
- cnt_clear never asserted two consecutive cycles from one command; back-to-back CLEARs give back-to-back pulses.
- cnt_value is observed only by the optional feature.

Optional Feature:
- Macro CNT_WRAP_TRACKER_AUTOCLR_EN.
- Defined: on event acceptance cnt_clear pulses one cycle, restarting counter phase; additionally, if cnt_value != 0 at acceptance, wrap_evt is ignored that cycle.
- Undefined: acceptance touches only tracker state; cnt_clear driven by ARM/CLEAR only.

Decomposition:
- Package counter_wrap_pkg: state enum (IDLE, ARMED, PENDING), cmd_op encodings (OP_NOP, OP_ARM, OP_DISARM, OP_CLEAR), default widths.
- One sub-module: sat_counter (WRAP_WIDTH saturating incrementer with synchronous zero/load), instantiated for wraps.

Test Plan:
- Reset held low 3 cycles with cnt_full toggling -> wraps=0, evt_valid=0, cnt_clear=0; cmd_ready=1 first cycle after release.
- ARM threshold=3, cnt_full pulse every 16 cycles -> cnt_clear one cycle after ARM; evt_valid rises 1 cycle after third wrap, evt_wraps=3.
- PENDING with evt_ready=0 for 40 cycles -> evt_valid/evt_wraps stable, cmd_ready=0, wraps=5; then evt_ready=1 -> ARMED, wraps=0.
- IDLE, cnt_full held high 300 cycles -> wraps saturates at 255, no rollover.
- CLEAR issued in same cycle as cnt_full, ARMED threshold=1 -> no event, wraps=0, cnt_clear pulsed once.
- ARM threshold=0 -> state IDLE, wraps=0, no event after 5 wraps; with CNT_WRAP_TRACKER_AUTOCLR_EN, acceptance of threshold=2 event produces cnt_clear pulse.

Source files
------------

// File: rtl/counter_wrap_pkg.sv
// Shared types for the counter wrap tracker: FSM states, command opcodes and
// default widths.
package counter_wrap_pkg;

    localparam int CNT_WIDTH_DEF  = 4;
    localparam int WRAP_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_ARM    = 2'd1,
        OP_DISARM = 2'd2,
        OP_CLEAR  = 2'd3
    } op_t;

endpackage

// File: rtl/counter_wrap_tracker_if.sv
// Command and event handshake bundle for the wrap tracker.
// Both channels are valid/ready: a beat transfers on a rising clk edge where
// valid && ready; the source holds its payload stable while valid && !ready.
interface counter_wrap_tracker_if #(
    parameter int WRAP_WIDTH = 8
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [WRAP_WIDTH-1:0] cmd_threshold;

    logic                  evt_valid;
    logic                  evt_ready;
    logic [WRAP_WIDTH-1:0] evt_wraps;

    modport master (
        output cmd_valid, cmd_op, cmd_threshold, evt_ready,
        input  cmd_ready, evt_valid, evt_wraps
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_threshold, evt_ready,
        output cmd_ready, evt_valid, evt_wraps
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous zero and load; zero beats load,
// load beats increment, and the count sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             zero,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (zero) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_wrap_tracker.sv
// Counts wrap-arounds of a free-running counter and raises a handshaked event
// when an armed threshold is reached. Optional macro: CNT_WRAP_TRACKER_AUTOCLR_EN.
module counter_wrap_tracker
    import counter_wrap_pkg::*;
#(
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int WRAP_WIDTH = WRAP_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CNT_WIDTH-1:0]  cnt_value,
    input  logic                  cnt_full,
    output logic                  cnt_clear,
    counter_wrap_tracker_if.slave bus,
    output logic [WRAP_WIDTH-1:0] wraps,
    output state_t                state
);

    state_t                state_q;
    state_t                state_d;
    op_t                   op;
    logic [WRAP_WIDTH-1:0] threshold;
    logic [WRAP_WIDTH-1:0] load_val;
    logic                  cmd_fire;
    logic                  evt_accept;
    logic                  wrap_evt;
    logic                  thr_hit;
    logic                  clear_req;
    logic                  cnt_zero;
    logic                  cnt_load;
    logic                  thr_load;
    logic                  evt_set;

    assign state         = state_q;
    assign op            = op_t'(bus.cmd_op);
    assign bus.cmd_ready = (state_q != PENDING);
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    assign evt_accept    = bus.evt_valid && bus.evt_ready;

    // A clear already in flight means the counter restarts instead of wrapping.
`ifdef CNT_WRAP_TRACKER_AUTOCLR_EN
    assign wrap_evt = cnt_full && !cnt_clear && !(evt_accept && (cnt_value != '0));
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_value;
    assign wrap_evt   = cnt_full && !cnt_clear;
`endif

    // Thresholds are never zero in ARMED, so a saturated count cannot match.
    assign thr_hit  = ((wraps + WRAP_WIDTH'(1)) == threshold);
    assign load_val = {{(WRAP_WIDTH-1){1'b0}}, wrap_evt};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clear_req = 1'b0;
        cnt_zero  = 1'b0;
        cnt_load  = 1'b0;
        thr_load  = 1'b0;
        evt_set   = 1'b0;
        case (state_q)
            IDLE, ARMED: begin
                if (cmd_fire && ((op == OP_CLEAR) ||
                                 ((op == OP_ARM) && (bus.cmd_threshold == '0)))) begin
                    cnt_zero  = 1'b1;
                    clear_req = 1'b1;
                    if (op == OP_ARM) begin
                        state_d = IDLE;
                    end
                end else if (cmd_fire && (op == OP_ARM)) begin
                    thr_load  = 1'b1;
                    cnt_zero  = 1'b1;
                    clear_req = 1'b1;
                    state_d   = ARMED;
                end else if (cmd_fire && (op == OP_DISARM)) begin
                    state_d = IDLE;
                end else if ((state_q == ARMED) && wrap_evt && thr_hit) begin
                    state_d = PENDING;
                    evt_set = 1'b1;
                end
            end
            PENDING: begin
                if (evt_accept) begin
                    state_d  = ARMED;
                    cnt_load = 1'b1;
`ifdef CNT_WRAP_TRACKER_AUTOCLR_EN
                    clear_req = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_clear     <= 1'b0;
            threshold     <= '0;
            bus.evt_valid <= 1'b0;
            bus.evt_wraps <= '0;
        end else begin
            cnt_clear <= clear_req;
            if (thr_load) begin
                threshold <= bus.cmd_threshold;
            end
            if (evt_set) begin
                bus.evt_valid <= 1'b1;
                bus.evt_wraps <= threshold;
            end else if (evt_accept) begin
                bus.evt_valid <= 1'b0;
            end
        end
    end

    sat_counter #(
        .WIDTH (WRAP_WIDTH)
    ) u_wraps (
        .clk      (clk),
        .reset    (reset),
        .zero     (cnt_zero),
        .load     (cnt_load),
        .load_val (load_val),
        .inc      (wrap_evt),
        .count    (wraps)
    );

endmodule

// File: tb/tb_counter_wrap_tracker.sv
// Randomized and directed bench for counter_wrap_tracker with a behavioural
// model and an event scoreboard drained by a separate monitor.
module tb_counter_wrap_tracker;
    import counter_wrap_pkg::*;

    localparam int WW   = 8;
    localparam int CW   = 4;
    localparam int MAXW = (1 << WW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] cnt_value = '0;
    logic          cnt_full = 1'b0;
    logic          cnt_clear;
    logic [WW-1:0] wraps;
    state_t        state;

    counter_wrap_tracker_if #(.WRAP_WIDTH(WW)) bus ();

    counter_wrap_tracker #(
        .CNT_WIDTH  (CW),
        .WRAP_WIDTH (WW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_value (cnt_value),
        .cnt_full  (cnt_full),
        .cnt_clear (cnt_clear),
        .bus       (bus),
        .wraps     (wraps),
        .state     (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: armed/pending flags, wrap count, threshold, clear pulse.
    bit            m_armed, m_pending, m_clear, m_last_fire;
    int            m_wraps, m_thr;
    logic [WW-1:0] exp_q[$];
    bit            chk_en = 1'b0;
    int            full_mode = 0;
    int            cyc = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_edge();
        bit fire, accept, wrap, nclr;
        int op;
        if (!reset) begin
            m_armed = 0; m_pending = 0; m_clear = 0; m_wraps = 0; m_thr = 0;
            m_last_fire = 0;
            return;
        end
        op     = int'(bus.cmd_op);
        fire   = bus.cmd_valid && !m_pending;
        accept = m_pending && bus.evt_ready;
        wrap   = cnt_full && !m_clear;
`ifdef CNT_WRAP_TRACKER_AUTOCLR_EN
        if (accept && (cnt_value != 0)) wrap = 0;
`endif
        nclr = 0;
        if (fire && (op == 3 || (op == 1 && bus.cmd_threshold == 0))) begin
            m_wraps = 0;
            nclr    = 1;
            if (op == 1) m_armed = 0;
        end else if (fire && op == 1) begin
            m_thr   = int'(bus.cmd_threshold);
            m_wraps = 0;
            nclr    = 1;
            m_armed = 1;
        end else if (accept) begin
            m_pending = 0;
            m_armed   = 1;
            m_wraps   = wrap ? 1 : 0;
`ifdef CNT_WRAP_TRACKER_AUTOCLR_EN
            nclr = 1;
`endif
        end else begin
            if (fire && op == 2) begin
                m_armed = 0;
            end else if (m_armed && wrap && (m_wraps + 1 == m_thr)) begin
                m_armed   = 0;
                m_pending = 1;
                exp_q.push_back(WW'(m_thr));
            end
            if (wrap) m_wraps = (m_wraps >= MAXW) ? MAXW : m_wraps + 1;
        end
        m_clear     = nclr;
        m_last_fire = fire;
    endfunction

    // One clock: advance the model on the inputs just sampled, then drive the
    // counter-side inputs for the next edge.
    task automatic tick();
        int v;
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
        case (full_mode)
            1: begin cnt_value = CW'(cyc % 16); cnt_full = ((cyc % 16) == 15); end
            2: begin cnt_value = '1; cnt_full = 1'b1; end
            3: begin
                v = ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 15);
                cnt_value = CW'(v);
                cnt_full  = (v == 15);
            end
            4: begin cnt_full = ~cnt_full; cnt_value = cnt_full ? '1 : '0; end
            default: begin cnt_value = CW'($urandom_range(0, 14)); cnt_full = 1'b0; end
        endcase
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [WW-1:0] thr);
        bus.cmd_valid     = 1'b1;
        bus.cmd_op        = op;
        bus.cmd_threshold = thr;
        m_last_fire       = 0;
        for (int i = 0; i < 200 && !m_last_fire; i++) tick();
        chk("cmd_accept", 32'(m_last_fire), 32'd1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_evt(input int budget);
        for (int i = 0; i < budget && !bus.evt_valid; i++) tick();
        chk("evt_raised", 32'(bus.evt_valid), 32'd1);
    endtask

    // Monitor: per-cycle outputs against the model, events against the queue.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wraps", 32'(wraps), 32'(m_wraps));
            chk("cnt_clear", 32'(cnt_clear), 32'(m_clear));
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_pending));
            chk("evt_valid", 32'(bus.evt_valid), 32'(m_pending));
            if (bus.evt_valid) begin
                if (exp_q.size() == 0) begin
                    chk("evt_expected", 32'd0, 32'd1);
                end else begin
                    chk("evt_wraps", 32'(bus.evt_wraps), 32'(exp_q[0]));
                    if (bus.evt_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_op        = 2'd0;
        bus.cmd_threshold = '0;
        bus.evt_ready     = 1'b0;

        // Reset held low with cnt_full toggling.
        full_mode = 4;
        repeat (3) tick();
        chk("rst_wraps", 32'(wraps), 32'd0);
        chk("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
        chk("rst_cnt_clear", 32'(cnt_clear), 32'd0);
        reset     = 1'b1;
        full_mode = 0;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk_en = 1'b1;
        tick();

        // ARM threshold 3 with a wrap every 16 cycles, then hold the event.
        full_mode = 1;
        send_cmd(OP_ARM, 8'd3);
        chk("arm_clear_pulse", 32'(cnt_clear), 32'd1);
        wait_evt(200);
        chk("evt_wraps_3", 32'(bus.evt_wraps), 32'd3);
        repeat (40) tick();
        chk("pend_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("pend_evt_wraps", 32'(bus.evt_wraps), 32'd3);
        bus.evt_ready = 1'b1;
        tick();
        bus.evt_ready = 1'b0;
        chk("accept_state", 32'(state), 32'(ARMED));

        // Saturation in IDLE.
        send_cmd(OP_DISARM, 8'd0);
        full_mode = 2;
        repeat (300) tick();
        chk("sat_wraps", 32'(wraps), 32'd255);

        // CLEAR colliding with a wrap while armed at threshold 1.
        full_mode = 0;
        send_cmd(OP_ARM, 8'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_CLEAR;
        cnt_full      = 1'b1;
        cnt_value     = '1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("clr_wraps", 32'(wraps), 32'd0);
        repeat (20) tick();
        chk("clr_no_evt", 32'(bus.evt_valid), 32'd0);

        // ARM with zero threshold behaves as CLEAR and stays idle.
        send_cmd(OP_ARM, 8'd0);
        full_mode = 1;
        repeat (90) tick();
        chk("arm0_state", 32'(state), 32'(IDLE));
        chk("arm0_no_evt", 32'(bus.evt_valid), 32'd0);

        // Threshold 2 event acceptance; counter clear only with auto-clear.
        send_cmd(OP_ARM, 8'd2);
        wait_evt(200);
        bus.evt_ready = 1'b1;
        tick();
        bus.evt_ready = 1'b0;
`ifdef CNT_WRAP_TRACKER_AUTOCLR_EN
        chk("accept_clear", 32'(cnt_clear), 32'd1);
`else
        chk("accept_clear", 32'(cnt_clear), 32'd0);
`endif

        // Random traffic; a command is held until the model sees it accepted.
        full_mode = 3;
        for (int i = 0; i < 3000; i++) begin
            tick();
            bus.evt_ready = 1'($urandom_range(0, 1));
            if (!bus.cmd_valid || m_last_fire) begin
                bus.cmd_valid     = ($urandom_range(0, 7) == 0);
                bus.cmd_op        = 2'($urandom_range(0, 3));
                bus.cmd_threshold = WW'($urandom_range(0, 4));
            end
        end
        full_mode     = 0;
        bus.cmd_valid = 1'b0;
        bus.evt_ready = 1'b1;
        repeat (10) tick();
        chk("evt_q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
